// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-source handshake and instruction-memory write bus for imem_loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              start;
  logic [ADDR_W-2:0] len_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, len_words, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );

  modport slave (
    input  start, len_words, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );
endinterface

// File: rtl/imem_word_packer.sv
// Byte-lane counter and little-endian assembly register for one 32-bit word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_accept,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [LANE_W-1:0] r_lane;
  logic [31:0]       r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_lane <= '0;
    end else if (i_accept) begin
      r_word[{r_lane, 3'b000} +: 8] <= i_byte;
      r_lane                        <= r_lane + 1'b1;
    end
  end

  // Strobes on the accept that completes the word, so the FSM leaves RECV on that edge.
  assign o_word_full = i_accept && (r_lane == LANE_W'(BYTES_PER_WORD - 1));
  assign o_word      = r_word;

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a byte stream, one little-endian word per write.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 7,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  localparam int unsigned WIDX_W    = ADDR_W - 1;
  localparam int unsigned CAP_WORDS = 2 ** (ADDR_W - 2);

  state_t              r_state;
  state_t              w_state_n;
  logic [WIDX_W-1:0]   r_len;
  logic [WIDX_W-1:0]   r_word_idx;
  logic [31:0]         r_mem_addr;
  logic                r_byte_ready;
  logic                r_mem_we;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                w_error_n;
  logic                w_clear;
  logic                w_accept;
  logic                w_word_full;
  logic [31:0]         w_word;

  assign w_accept = r_byte_ready & bus.byte_valid;

  imem_word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_accept    (w_accept),
    .i_clear     (w_clear),
    .i_byte      (bus.byte_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  always_comb begin
    w_state_n = r_state;
    w_error_n = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_clear = 1'b1;
          if (bus.len_words == '0)                    w_state_n = DONE;
          else if (32'(bus.len_words) > CAP_WORDS)    w_error_n = 1'b1;
          else                                        w_state_n = RECV;
        end
      end
      RECV: begin
        if (w_word_full) w_state_n = WRITE;
      end
      WRITE: begin
        w_clear = 1'b1;
        if (r_word_idx == r_len - WIDX_W'(1)) w_state_n = DONE;
        else                                  w_state_n = RECV;
      end
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_mem_addr   <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_byte_ready <= (w_state_n == RECV);
      r_mem_we     <= (w_state_n == WRITE);
      r_busy       <= (w_state_n != IDLE);
      r_done       <= (w_state_n == DONE);
      r_error      <= w_error_n;
      if (r_state == IDLE && bus.start) begin
        r_len      <= bus.len_words;
        r_word_idx <= '0;
      end
      if (r_state == RECV && w_word_full)
        r_mem_addr <= BASE_ADDR + {{(32 - WIDX_W - 2){1'b0}}, r_word_idx, 2'b00};
      if (r_state == WRITE && w_state_n == RECV)
        r_word_idx <= r_word_idx + 1'b1;
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = w_word;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule
